// File: rtl/display_pkg.sv
// Shared constants for the session display: segment codes, conversion FSM states, helpers.
package display_pkg;

  localparam int NUM_DIGITS = 5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} conv_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction applied to each BCD nibble before the shift.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative 8-bit binary to 12-bit BCD converter, one shift-add-3 step per clock.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [7:0]  bin_i,
  output logic [11:0] bcd_o,
  output logic        done_o
);

  logic [19:0] shift_q;
  logic [19:0] adj;
  logic [2:0]  cnt_q;
  logic        run_q;

  assign adj = {add3(shift_q[19:16]), add3(shift_q[15:12]), add3(shift_q[11:8]), shift_q[7:0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else if (start_i) begin
      shift_q <= {12'd0, bin_i};
      cnt_q   <= '0;
      run_q   <= 1'b1;
    end else if (run_q) begin
      shift_q <= {adj[18:0], 1'b0};
      cnt_q   <= cnt_q + 3'd1;
      if (cnt_q == 3'd7) run_q <= 1'b0;
    end
  end

  // done_o flags the final iteration; bcd_o is valid from the following cycle.
  assign done_o = run_q && (cnt_q == 3'd7);
  assign bcd_o  = shift_q[19:8];

endmodule

// File: rtl/session_display.sv
// Presentation stage: BCD conversion of scheduler values, 5-digit 7-segment scan, beep stretcher.
module session_display
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 4,
  parameter int BEEP_LEN    = 8,
  parameter int BEEP_GAP    = 8,
  parameter int BEEP_COUNT  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] workout_num,
  input  logic [5:0] time_remain,
  input  logic [7:0] T,
  input  logic       buzzer,
  input  logic       show_total,
  output logic [6:0] seg_n,
  output logic [4:0] anode_n,
  output logic       beep,
  output logic       busy
);

  localparam int REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BEEP_MX = (BEEP_LEN > BEEP_GAP) ? BEEP_LEN : BEEP_GAP;
  localparam int BEEP_W  = $clog2(BEEP_MX + 1);
  localparam int PULSE_W = $clog2(BEEP_COUNT + 1);

  conv_state_e state_q, state_d;
  logic        start;
  logic [7:0]  upper_sel;
  logic [13:0] key_cur, key_q, conv_key_q;
  logic [11:0] up_bcd, tr_bcd, bcd_up_q;
  logic [7:0]  bcd_tr_q;
  logic        up_done, tr_done_unused;
  logic [3:0]  tr_hi_unused;

  assign upper_sel    = show_total ? T : workout_num;
  assign key_cur      = {upper_sel, time_remain};
  assign tr_hi_unused = tr_bcd[11:8];

  bin2bcd_seq u_conv_upper (
    .clk     (clk),
    .reset   (reset),
    .start_i (start),
    .bin_i   (upper_sel),
    .bcd_o   (up_bcd),
    .done_o  (up_done)
  );

  bin2bcd_seq u_conv_time (
    .clk     (clk),
    .reset   (reset),
    .start_i (start),
    .bin_i   ({2'b00, time_remain}),
    .bcd_o   (tr_bcd),
    .done_o  (tr_done_unused)
  );

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_cur != key_q) begin
          start   = 1'b1;
          state_d = CONV;
        end
      end
      CONV:    if (up_done) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The key captured at start is the one committed, so edits during CONV re-trigger later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      key_q      <= '0;
      conv_key_q <= '0;
      bcd_up_q   <= '0;
      bcd_tr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) conv_key_q <= key_cur;
      if (state_q == COMMIT) begin
        key_q    <= conv_key_q;
        bcd_up_q <= up_bcd;
        bcd_tr_q <= tr_bcd[7:0];
      end
    end
  end

  assign busy = (state_q != IDLE);

  logic [6:0]       digit_code [NUM_DIGITS];
  logic [REF_W-1:0] refresh_q;
  logic [2:0]       digit_idx_q;
  logic [6:0]       seg_q;
  logic [4:0]       anode_q;

  assign digit_code[0] = seg_decode(bcd_tr_q[3:0]);
  assign digit_code[1] = seg_decode(bcd_tr_q[7:4]);
  assign digit_code[2] = seg_decode(bcd_up_q[3:0]);
  assign digit_code[3] = (bcd_up_q[11:4] == 8'd0) ? SEG_BLANK : seg_decode(bcd_up_q[7:4]);
  assign digit_code[4] = (bcd_up_q[11:8] == 4'd0) ? SEG_BLANK : seg_decode(bcd_up_q[11:8]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      refresh_q   <= '0;
      digit_idx_q <= '0;
      seg_q       <= SEG_BLANK;
      anode_q     <= 5'h1F;
    end else begin
      anode_q <= ~(5'(1) << digit_idx_q);
      seg_q   <= digit_code[digit_idx_q];
      if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
        refresh_q   <= '0;
        digit_idx_q <= (digit_idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : digit_idx_q + 3'd1;
      end else begin
        refresh_q <= refresh_q + REF_W'(1);
      end
    end
  end

  assign seg_n   = seg_q;
  assign anode_n = anode_q;

  logic              buzzer_q, trig_q, beep_q, beep_act_q;
  logic [BEEP_W-1:0]  beep_cnt_q;
  logic [PULSE_W-1:0] pulse_q;

  // History resets high so a buzzer already asserted through reset is not an event.
  always_ff @(posedge clk) begin
    if (!reset) begin
      buzzer_q   <= 1'b1;
      trig_q     <= 1'b0;
      beep_q     <= 1'b0;
      beep_act_q <= 1'b0;
      beep_cnt_q <= '0;
      pulse_q    <= '0;
    end else begin
      buzzer_q <= buzzer;
      trig_q   <= buzzer & ~buzzer_q;
      if (trig_q) begin
        beep_act_q <= 1'b1;
        beep_q     <= 1'b1;
        beep_cnt_q <= '0;
        pulse_q    <= '0;
      end else if (beep_act_q) begin
        if (beep_q) begin
          if (beep_cnt_q == BEEP_W'(BEEP_LEN - 1)) begin
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
          end else begin
            beep_cnt_q <= beep_cnt_q + BEEP_W'(1);
          end
        end else if (beep_cnt_q == BEEP_W'(BEEP_GAP - 1)) begin
          beep_cnt_q <= '0;
          if (pulse_q == PULSE_W'(BEEP_COUNT - 1)) begin
            beep_act_q <= 1'b0;
          end else begin
            pulse_q <= pulse_q + PULSE_W'(1);
            beep_q  <= 1'b1;
          end
        end else begin
          beep_cnt_q <= beep_cnt_q + BEEP_W'(1);
        end
      end
    end
  end

  assign beep = beep_q;

endmodule

// File: tb/tb_session_display.sv
// Directed bench for session_display: reset, conversions, digit scan, beep patterns, aborts.
module tb_session_display;

  localparam int RDIV = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] workout_num;
  logic [5:0] time_remain;
  logic [7:0] T;
  logic       buzzer;
  logic       show_total;
  logic [6:0] seg_n;
  logic [4:0] anode_n;
  logic       beep;
  logic       busy;

  int checks = 0;
  int errors = 0;

  session_display #(
    .REFRESH_DIV (RDIV),
    .BEEP_LEN    (8),
    .BEEP_GAP    (8),
    .BEEP_COUNT  (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .workout_num (workout_num),
    .time_remain (time_remain),
    .T           (T),
    .buzzer      (buzzer),
    .show_total  (show_total),
    .seg_n       (seg_n),
    .anode_n     (anode_n),
    .beep        (beep),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_digit(input int d, input logic [6:0] exp, input string tag);
    logic [4:0] want;
    logic       found;
    want  = ~(5'b00001 << d);
    found = 1'b0;
    for (int g = 0; g < 30; g++) begin
      tick();
      if (anode_n === want) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check({tag, "_found"}, {63'd0, found}, 64'd1);
    else check(tag, {57'd0, seg_n}, {57'd0, exp});
    $display("digit %0d anode=%h seg=%h (want %h)", d, anode_n, seg_n, exp);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    for (int g = 0; g < 40; g++) begin
      if (busy !== 1'b1) break;
      n++;
      tick();
    end
  endtask

  initial begin
    int         n;
    int         hits;
    int         bones;
    logic [47:0] bvec;
    logic [63:0] rvec;
    logic        ors;

    reset = 1'b0; workout_num = 8'd0; time_remain = 6'd0; T = 8'd0;
    buzzer = 1'b0; show_total = 1'b0;
    tick(); tick(); tick();
    check("rst_seg", {57'd0, seg_n}, 64'h7F);
    check("rst_anode", {59'd0, anode_n}, 64'h1F);
    check("rst_beep", {63'd0, beep}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);

    reset = 1'b1;
    tick();
    check("first_anode", {59'd0, anode_n}, 64'h1E);
    check("first_seg", {57'd0, seg_n}, 64'h40);
    check("first_busy", {63'd0, busy}, 64'd0);
    tick(); tick(); tick(); tick();
    check("zero_busy", {63'd0, busy}, 64'd0);
    chk_digit(2, 7'h40, "zero_d2");
    chk_digit(3, 7'h7F, "zero_d3");
    chk_digit(4, 7'h7F, "zero_d4");
    $display("step reset done");

    workout_num = 8'd203; time_remain = 6'd47; show_total = 1'b0;
    tick();
    check("conv_busy_rise", {63'd0, busy}, 64'd1);
    busy_len(n);
    check("conv_busy_len", 64'(n), 64'd9);
    chk_digit(4, 7'h24, "c203_d4");
    chk_digit(3, 7'h40, "c203_d3");
    chk_digit(2, 7'h30, "c203_d2");
    chk_digit(1, 7'h19, "c47_d1");
    chk_digit(0, 7'h78, "c47_d0");
    $display("step conversion 203/47 done");

    T = 8'd9; show_total = 1'b1;
    tick();
    check("sel_busy_rise", {63'd0, busy}, 64'd1);
    busy_len(n);
    check("sel_busy_len", 64'(n), 64'd9);
    chk_digit(4, 7'h7F, "t9_d4");
    chk_digit(3, 7'h7F, "t9_d3");
    chk_digit(2, 7'h10, "t9_d2");
    $display("step source select done");

    buzzer = 1'b1;
    tick();
    check("beep_k", {63'd0, beep}, 64'd0);
    tick();
    for (int i = 0; i < 48; i++) begin
      bvec[i] = beep;
      if (i == 0) buzzer = 1'b0;
      tick();
    end
    check("beep_pattern", {16'd0, bvec}, 64'h0000_00FF_00FF_00FF);
    $display("step beep pattern %h", bvec);
    tick(); tick(); tick(); tick();

    buzzer = 1'b1;
    tick(); tick();
    for (int i = 0; i < 64; i++) begin
      rvec[i] = beep;
      if (i == 0) buzzer = 1'b0;
      if (i == 10) buzzer = 1'b1;
      if (i == 20) buzzer = 1'b0;
      tick();
    end
    check("beep_restart", rvec, 64'h000F_F00F_F00F_F0FF);
    $display("step beep restart %h", rvec);

    workout_num = 8'd77; time_remain = 6'd5; show_total = 1'b0;
    tick();
    check("abort_busy_rise", {63'd0, busy}, 64'd1);
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    check("abort_seg", {57'd0, seg_n}, 64'h7F);
    check("abort_anode", {59'd0, anode_n}, 64'h1F);
    check("abort_busy", {63'd0, busy}, 64'd0);
    reset = 1'b1;
    tick();
    check("abort_rel_anode", {59'd0, anode_n}, 64'h1E);
    check("abort_rel_seg", {57'd0, seg_n}, 64'h40);
    check("abort_rel_busy", {63'd0, busy}, 64'd1);
    busy_len(n);
    check("abort_rerun_len", 64'(n), 64'd9);
    chk_digit(4, 7'h7F, "c77_d4");
    chk_digit(3, 7'h78, "c77_d3");
    chk_digit(2, 7'h78, "c77_d2");
    chk_digit(1, 7'h40, "c05_d1");
    chk_digit(0, 7'h12, "c05_d0");
    $display("step reset during conversion done");

    buzzer = 1'b1;
    tick(); tick(); tick(); tick();
    check("beep_on_before_rst", {63'd0, beep}, 64'd1);
    reset = 1'b0;
    tick();
    check("beep_rst_beep", {63'd0, beep}, 64'd0);
    check("beep_rst_anode", {59'd0, anode_n}, 64'h1F);
    check("beep_rst_seg", {57'd0, seg_n}, 64'h7F);
    reset = 1'b1;
    ors = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      ors = ors | beep;
    end
    check("beep_held_high_silent", {63'd0, ors}, 64'd0);
    buzzer = 1'b0;
    check("beep_rst_idle_busy", {63'd0, busy}, 64'd0);
    $display("step reset during beep done");

    workout_num = 8'd0; time_remain = 6'd10;
    tick();
    check("chg_busy_rise", {63'd0, busy}, 64'd1);
    tick(); tick(); tick();
    time_remain = 6'd63;
    busy_len(n);
    check("chg_first_len", 64'(n), 64'd6);
    hits = 0;
    bones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy === 1'b1) bones++;
      if (anode_n === 5'h1E) begin
        hits++;
        check("chg_first_d0", {57'd0, seg_n}, 64'h40);
      end
      if (anode_n === 5'h1D) begin
        hits++;
        check("chg_first_d1", {57'd0, seg_n}, 64'h79);
      end
    end
    check("chg_first_hits", 64'(hits), 64'd4);
    check("chg_second_busy", 64'(bones), 64'd9);
    check("chg_second_idle", {63'd0, busy}, 64'd0);
    chk_digit(1, 7'h02, "c63_d1");
    chk_digit(0, 7'h30, "c63_d0");
    $display("step input change while busy done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
